// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding and the
// default width of the significant byte address.
package icache_pkg;

    localparam int ICACHE_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data store: one combinational read port, one write
// port and a bulk clear of all valid bits. Clear wins over a same-edge write.
module icache_array #(
    parameter int LINES = 32,
    parameter int TAG_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [31:0]              rd_data,
    input  logic                     we,
    input  logic                     wr_valid,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [31:0]              wr_data
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // Valid bits: cleared by reset or flush, otherwise updated by a line fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (en) begin
            if (clr) begin
                valid_q <= '0;
            end else if (we) begin
                valid_q[wr_idx] <= wr_valid;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (en && we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between the fetch stage
// and the memory controller instruction port. Hits return data in the same
// cycle; misses run a single-word fill through REQ/WAIT/DONE.
module icache
    import icache_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int ADDR_W = icache_pkg::ICACHE_ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        inst_re,
    input  logic [31:0] inst_raddr,
    output logic [31:0] inst_rdata,
    output logic        inst_rbusy,
    output logic        ram_re,
    output logic [31:0] ram_raddr,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rbusy
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;      // latched word address (byte addr 31:2)
    logic [31:0] word_q, word_d;      // word captured from the controller
    logic        kill_q, kill_d;      // flush seen during the current fill

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             arr_we;
    logic             arr_wvalid;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^inst_raddr[1:0];

    icache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .clr      (flush),
        .rd_idx   (inst_raddr[IDX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (arr_we),
        .wr_valid (arr_wvalid),
        .wr_idx   (addr_q[IDX_W-1:0]),
        .wr_tag   (addr_q[ADDR_W-3:IDX_W]),
        .wr_data  (ram_rdata)
    );

    assign hit       = rd_valid && (rd_tag == inst_raddr[ADDR_W-1:IDX_W+2]);
    assign ram_raddr = {addr_q, 2'b00};

    // Control state register; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            kill_q  <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state and output decode for the lookup/fill sequence.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        kill_d     = kill_q;
        inst_rdata = '0;
        inst_rbusy = 1'b0;
        ram_re     = 1'b0;
        arr_we     = 1'b0;
        arr_wvalid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inst_re) begin
                    if (hit) begin
                        inst_rdata = rd_data;
                    end else begin
                        inst_rbusy = 1'b1;
                        addr_d     = inst_raddr[31:2];
                        kill_d     = 1'b0;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                ram_re     = 1'b1;
                inst_rbusy = 1'b1;
                if (flush) kill_d = 1'b1;
                if (ram_rbusy) state_d = WAIT;
            end
            WAIT: begin
                ram_re     = 1'b1;
                inst_rbusy = 1'b1;
                if (flush) kill_d = 1'b1;
                if (!ram_rbusy) begin
                    // A flush earlier in this fill keeps the new line invalid;
                    // a flush on this very edge is handled by the array's clear.
                    arr_we     = 1'b1;
                    arr_wvalid = !kill_q;
                    word_d     = ram_rdata;
                    state_d    = DONE;
                end
            end
            DONE: begin
                inst_rdata = word_q;
                inst_rbusy = (inst_raddr[31:2] != addr_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
